// File: rtl/lwc_do_buffer_if.sv
// Cipher-output (pdo_*) and external-output (do_*) stream signals of the output buffer.
// slave is the buffer's view; master is the surrounding producer/consumer view.
interface lwc_do_buffer_if #(
    parameter int BUSW = 32
);
    logic [BUSW-1:0] pdo_data;
    logic            pdo_valid;
    logic            pdo_last;
    logic            pdo_ready;
    logic [BUSW-1:0] do_data;
    logic            do_valid;
    logic            do_last;
    logic            do_ready;

    modport slave (
        input  pdo_data, pdo_valid, pdo_last, do_ready,
        output pdo_ready, do_data, do_valid, do_last
    );

    modport master (
        output pdo_data, pdo_valid, pdo_last, do_ready,
        input  pdo_ready, do_data, do_valid, do_last
    );
endinterface

// File: rtl/lwc_do_buffer.sv
// Output buffer between the cipher control unit and the external data-out port:
// a circular FIFO of {last, data} with a drained-message counter.
module lwc_do_buffer #(
    parameter int BUSW  = 32,
    parameter int DEPTH = 4,
    parameter int LVLW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    lwc_do_buffer_if.slave    bus,
    output logic [LVLW-1:0]   level,
    output logic [15:0]       msg_count
);
    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LVLW-1:0] FULL_LVL = LVLW'(DEPTH);

    logic [BUSW:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0] level_q, level_d;
    logic [15:0]     msg_count_q, msg_count_d;
    logic            not_full;
    logic            not_empty;
    logic            push;
    logic            pop;
    logic [BUSW:0]   head;

    // Ready/valid depend only on level_q, so there is no do_ready -> pdo_ready path.
    always_comb begin
        not_full    = (level_q != FULL_LVL);
        not_empty   = (level_q != '0);
        push        = bus.pdo_valid && not_full;
        pop         = bus.do_ready && not_empty;
        head        = mem_q[rd_ptr_q];
        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d     = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVLW'(1);
            2'b01:   level_d = level_q - LVLW'(1);
            default: level_d = level_q;
        endcase
        msg_count_d = (pop && head[BUSW]) ? msg_count_q + 16'd1 : msg_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            msg_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            msg_count_q <= msg_count_d;
        end
    end

    // Storage is left unreset; stale entries are masked by the empty check below.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.pdo_last, bus.pdo_data};
        end
    end

    assign bus.pdo_ready = not_full;
    assign bus.do_valid  = not_empty;
    assign bus.do_data   = not_empty ? head[BUSW-1:0] : '0;
    assign bus.do_last   = not_empty & head[BUSW];
    assign level         = level_q;
    assign msg_count     = msg_count_q;
endmodule

// File: tb/tb_lwc_do_buffer.sv
// Scoreboard bench for lwc_do_buffer: accepted words are queued, popped words are
// compared in order by a negedge monitor; each scenario task checks levels and flags.
module tb_lwc_do_buffer;
    localparam int BUSW  = 32;
    localparam int DEPTH = 4;
    localparam int LVLW  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [LVLW-1:0] level;
    logic [15:0]     msg_count;
    int              total = 0;
    int              bad   = 0;
    logic [BUSW:0]   sb [$];
    logic [BUSW:0]   exp_w;

    lwc_do_buffer_if #(.BUSW(BUSW)) bus ();

    lwc_do_buffer #(.BUSW(BUSW), .DEPTH(DEPTH), .LVLW(LVLW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .level     (level),
        .msg_count (msg_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 after the rising edge; the monitor samples on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.do_valid && bus.do_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected got last=%b data=%h, required no word", bus.do_last, bus.do_data);
                end else begin
                    exp_w = sb.pop_front();
                    if ({bus.do_last, bus.do_data} !== exp_w) begin
                        bad++;
                        $display("FAIL pop_word got last=%b data=%h, required last=%b data=%h",
                                 bus.do_last, bus.do_data, exp_w[BUSW], exp_w[BUSW-1:0]);
                    end
                end
            end
            if (bus.pdo_valid && bus.pdo_ready) sb.push_back({bus.pdo_last, bus.pdo_data});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.pdo_valid = 1'b0;
        bus.pdo_last  = 1'b0;
        bus.pdo_data  = '0;
        bus.do_ready  = 1'b0;
        sb.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.pdo_valid = 1'b1;
        bus.pdo_last  = 1'b1;
        bus.pdo_data  = 32'hFFFF_FFFF;
        bus.do_ready  = 1'b1;
        step();
        step();
        total++; if (bus.do_valid !== 1'b0) begin bad++; $display("FAIL rst_do_valid got=%b required=0", bus.do_valid); end
        total++; if (bus.do_data !== 32'h0) begin bad++; $display("FAIL rst_do_data got=%h required=0", bus.do_data); end
        total++; if (bus.do_last !== 1'b0) begin bad++; $display("FAIL rst_do_last got=%b required=0", bus.do_last); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d required=0", level); end
        total++; if (msg_count !== 16'h0) begin bad++; $display("FAIL rst_msg_count got=%h required=0", msg_count); end
        bus.pdo_valid = 1'b0;
        bus.do_ready  = 1'b0;
        rst           = 1'b0;
        sb.delete();
        #1;
        total++; if (bus.pdo_ready !== 1'b1) begin bad++; $display("FAIL rst_pdo_ready got=%b required=1", bus.pdo_ready); end
    endtask

    task automatic test_latency();
        apply_reset();
        bus.pdo_data  = 32'h1111_1111;
        bus.pdo_last  = 1'b0;
        bus.pdo_valid = 1'b1;
        #1;
        total++; if (bus.do_valid !== 1'b0) begin bad++; $display("FAIL no_fallthrough got do_valid=%b required=0", bus.do_valid); end
        step();
        bus.pdo_valid = 1'b0;
        bus.pdo_data  = 32'hDEAD_BEEF;
        total++; if (bus.do_valid !== 1'b1) begin bad++; $display("FAIL lat_do_valid got=%b required=1", bus.do_valid); end
        total++; if (bus.do_data !== 32'h1111_1111) begin bad++; $display("FAIL lat_do_data got=%h required=11111111", bus.do_data); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL lat_level got=%0d required=1", level); end
        bus.do_ready = 1'b1;
        step();
        bus.do_ready = 1'b0;
        total++; if (level !== 3'd0) begin bad++; $display("FAIL lat_drained_level got=%0d required=0", level); end
        total++; if (bus.do_data !== 32'h0) begin bad++; $display("FAIL lat_empty_data got=%h required=0", bus.do_data); end
    endtask

    task automatic test_fill_drain();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            bus.pdo_data  = 32'hA0 + 32'(i);
            bus.pdo_last  = (i == 3);
            bus.pdo_valid = 1'b1;
            step();
        end
        bus.pdo_valid = 1'b0;
        total++; if (level !== 3'd4) begin bad++; $display("FAIL full_level got=%0d required=4", level); end
        total++; if (bus.pdo_ready !== 1'b0) begin bad++; $display("FAIL full_pdo_ready got=%b required=0", bus.pdo_ready); end
        step();
        total++; if (bus.do_data !== 32'hA0 || bus.do_last !== 1'b0) begin
            bad++; $display("FAIL hold_stable got last=%b data=%h required last=0 data=000000a0", bus.do_last, bus.do_data);
        end
        bus.do_ready = 1'b1;
        repeat (4) step();
        bus.do_ready = 1'b0;
        total++; if (msg_count !== 16'd1) begin bad++; $display("FAIL drain_msg_count got=%0d required=1", msg_count); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL drain_level got=%0d required=0", level); end
        total++; if (bus.do_valid !== 1'b0) begin bad++; $display("FAIL drain_do_valid got=%b required=0", bus.do_valid); end
    endtask

    task automatic test_full_simul();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            bus.pdo_data  = 32'hB0 + 32'(i);
            bus.pdo_last  = 1'b0;
            bus.pdo_valid = 1'b1;
            step();
        end
        bus.pdo_data  = 32'hB4;
        bus.pdo_last  = 1'b1;
        bus.do_ready  = 1'b1;
        total++; if (bus.pdo_ready !== 1'b0) begin bad++; $display("FAIL full_pop_ready got=%b required=0", bus.pdo_ready); end
        step();
        bus.do_ready = 1'b0;
        total++; if (level !== 3'd3) begin bad++; $display("FAIL full_pop_level got=%0d required=3", level); end
        total++; if (bus.pdo_ready !== 1'b1) begin bad++; $display("FAIL freed_ready got=%b required=1", bus.pdo_ready); end
        step();
        bus.pdo_valid = 1'b0;
        total++; if (level !== 3'd4) begin bad++; $display("FAIL refill_level got=%0d required=4", level); end
        bus.do_ready = 1'b1;
        for (int n = 0; n < 10 && level != 3'd0; n++) step();
        bus.do_ready = 1'b0;
        total++; if (level !== 3'd0) begin bad++; $display("FAIL full_drain_timeout got level=%0d required=0", level); end
        total++; if (msg_count !== 16'd1) begin bad++; $display("FAIL full_msg_count got=%0d required=1", msg_count); end
    endtask

    task automatic test_stream();
        apply_reset();
        bus.do_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.pdo_data  = $urandom;
            bus.pdo_last  = (i == 9);
            bus.pdo_valid = 1'b1;
            step();
            total++; if (level !== 3'd1) begin bad++; $display("FAIL stream_level beat=%0d got=%0d required=1", i, level); end
        end
        bus.pdo_valid = 1'b0;
        step();
        bus.do_ready = 1'b0;
        total++; if (level !== 3'd0) begin bad++; $display("FAIL stream_end_level got=%0d required=0", level); end
        total++; if (msg_count !== 16'd1) begin bad++; $display("FAIL stream_msg_count got=%0d required=1", msg_count); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL stream_leftover got=%0d words required=0", sb.size()); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            bus.pdo_data  = 32'hC0 + 32'(i);
            bus.pdo_last  = (i == 1);
            bus.pdo_valid = 1'b1;
            step();
        end
        bus.pdo_valid = 1'b0;
        total++; if (level !== 3'd2) begin bad++; $display("FAIL pre_rst_level got=%0d required=2", level); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.do_valid !== 1'b0) begin bad++; $display("FAIL arst_do_valid got=%b required=0", bus.do_valid); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL arst_level got=%0d required=0", level); end
        total++; if (bus.do_data !== 32'h0) begin bad++; $display("FAIL arst_do_data got=%h required=0", bus.do_data); end
        total++; if (msg_count !== 16'h0) begin bad++; $display("FAIL arst_msg_count got=%0d required=0", msg_count); end
        sb.delete();
        step();
        rst          = 1'b0;
        bus.do_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (bus.do_valid !== 1'b0) begin bad++; $display("FAIL arst_stale cycle=%0d got do_valid=%b required=0", i, bus.do_valid); end
        end
        bus.do_ready = 1'b0;
    endtask

    task automatic test_msg_wrap();
        apply_reset();
        bus.do_ready  = 1'b1;
        bus.pdo_last  = 1'b1;
        bus.pdo_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus.pdo_data = 32'(i);
            step();
        end
        bus.pdo_valid = 1'b0;
        step();
        total++; if (msg_count !== 16'hFFFF) begin bad++; $display("FAIL msg_preload got=%h required=ffff", msg_count); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL msg_preload_level got=%0d required=0", level); end
        bus.pdo_data  = 32'h5A5A_5A5A;
        bus.pdo_valid = 1'b1;
        step();
        bus.pdo_valid = 1'b0;
        step();
        bus.do_ready = 1'b0;
        total++; if (msg_count !== 16'h0000) begin bad++; $display("FAIL msg_wrap got=%h required=0000", msg_count); end
    endtask

    initial begin
        #5_000_000;
        bad++;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_fill_drain();
        test_full_simul();
        test_stream();
        test_async_reset();
        test_msg_wrap();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
